// File: rtl/fft_frame_pkg.sv
// Shared types and helpers for the FFT frame controller: reduction modes,
// source FSM states, saturating magnitude and group-size arithmetic.
package fft_frame_pkg;

    localparam int MAG_MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_DECIM = 2'd0,
        MODE_PEAK  = 2'd1,
        MODE_AVG   = 2'd2
    } mode_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } src_state_e;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_PEAK;
            2'd2:    m = MODE_AVG;
            default: m = MODE_DECIM;
        endcase
        return m;
    endfunction

    // Number of FFT points per display bin, as a shift amount
    function automatic int group_shift(input int fft_len, input int num_bins);
        return $clog2(fft_len / (2 * num_bins));
    endfunction

    // |re|+|im| clamped to the largest unsigned value representable in data_w bits;
    // callers pass sign-extended operands narrower than MAG_MAX_W.
    function automatic logic [MAG_MAX_W-1:0] mag_sat(
        input logic signed [MAG_MAX_W-1:0] re,
        input logic signed [MAG_MAX_W-1:0] im,
        input int unsigned                 data_w
    );
        logic [MAG_MAX_W:0] abs_re;
        logic [MAG_MAX_W:0] abs_im;
        logic [MAG_MAX_W:0] sum;
        logic [MAG_MAX_W:0] lim;
        abs_re = re[MAG_MAX_W-1] ? {1'b0, -re} : {1'b0, re};
        abs_im = im[MAG_MAX_W-1] ? {1'b0, -im} : {1'b0, im};
        sum    = abs_re + abs_im;
        lim    = (33'd1 << data_w) - 33'd1;
        return (sum > lim) ? lim[MAG_MAX_W-1:0] : sum[MAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for incoming audio samples; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Storage and pointer update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Streams buffered audio into the FFT sink and reduces the first half of each
// FFT output frame into a double-buffered bin vector for the visualiser.
module fft_frame_ctrl
    import fft_frame_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FFT_LEN    = 512,
    parameter int NUM_BINS   = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sample_valid,
    input  logic [DATA_W-1:0]          i_sample,
    input  logic [1:0]                 i_mode,
    output logic                       o_sink_valid,
    input  logic                       i_sink_ready,
    output logic                       o_sink_sop,
    output logic                       o_sink_eop,
    output logic [DATA_W-1:0]          o_sink_real,
    input  logic                       i_src_valid,
    output logic                       o_src_ready,
    input  logic                       i_src_sop,
    input  logic                       i_src_eop,
    input  logic [DATA_W-1:0]          i_src_real,
    input  logic [DATA_W-1:0]          i_src_imag,
    input  logic [1:0]                 i_src_error,
    output logic [NUM_BINS*DATA_W-1:0] o_bins,
    output logic                       o_frame_done,
    output logic                       o_overflow,
    output logic                       o_framing_err,
    output logic [1:0]                 o_fft_error
);

    localparam int CNT_W  = $clog2(FFT_LEN);
    localparam int GSHIFT = group_shift(FFT_LEN, NUM_BINS);
    localparam int ACC_W  = DATA_W + GSHIFT;
    localparam int BIN_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FFT_LEN - 1);
    localparam logic [CNT_W-1:0] HALF_IDX   = CNT_W'(FFT_LEN / 2);
    localparam logic [CNT_W-1:0] GROUP_MASK = CNT_W'((1 << GSHIFT) - 1);

    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [DATA_W-1:0]        fifo_dout_s;
    logic                     xfer_s;
    logic [CNT_W-1:0]         sink_cnt_r;
    logic                     overflow_r;

    src_state_e               state_r;
    logic [CNT_W-1:0]         src_cnt_r;
    mode_e                    mode_r;
    logic [ACC_W-1:0]         acc_r;
    logic [DATA_W-1:0]        shadow_r [NUM_BINS];
    logic [NUM_BINS*DATA_W-1:0] bins_r;
    logic                     frame_done_r;
    logic                     framing_err_r;
    logic [1:0]               fft_error_r;

    logic                     restart_s;
    logic                     process_s;
    logic [CNT_W-1:0]         idx_s;
    mode_e                    eff_mode_s;
    logic [MAG_MAX_W-1:0]     mag_full_s;
    logic [DATA_W-1:0]        mag_s;
    logic                     in_range_s;
    logic                     first_s;
    logic                     last_s;
    logic [BIN_W-1:0]         bin_s;
    logic [ACC_W-1:0]         acc_next_s;
    logic [DATA_W-1:0]        result_s;

    sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (i_sample_valid),
        .pop   (xfer_s),
        .din   (i_sample),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    // Valid depends only on FIFO state, so ready never loops back into it
    assign xfer_s        = !fifo_empty_s && i_sink_ready;
    assign o_sink_valid  = !fifo_empty_s;
    assign o_sink_real   = fifo_dout_s;
    assign o_sink_sop    = !fifo_empty_s && (sink_cnt_r == '0);
    assign o_sink_eop    = !fifo_empty_s && (sink_cnt_r == LAST_IDX);
    assign o_src_ready   = 1'b1;
    assign o_bins        = bins_r;
    assign o_frame_done  = frame_done_r;
    assign o_overflow    = overflow_r;
    assign o_framing_err = framing_err_r;
    assign o_fft_error   = fft_error_r;

    // Sink packet position and sticky drop flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sink_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                sink_cnt_r <= (sink_cnt_r == LAST_IDX) ? '0 : sink_cnt_r + CNT_W'(1);
            end
            if (i_sample_valid && fifo_full_s && !xfer_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Per-beat reduction datapath; a sop beat always starts a fresh frame at index 0
    always_comb begin
        restart_s  = i_src_valid && i_src_sop;
        process_s  = restart_s || (i_src_valid && (state_r == S_COLLECT));
        idx_s      = restart_s ? '0 : src_cnt_r;
        eff_mode_s = restart_s ? decode_mode(i_mode) : mode_r;
        mag_full_s = mag_sat(MAG_MAX_W'($signed(i_src_real)),
                             MAG_MAX_W'($signed(i_src_imag)), DATA_W);
        mag_s      = mag_full_s[DATA_W-1:0];
        in_range_s = (idx_s < HALF_IDX);
        first_s    = ((idx_s & GROUP_MASK) == '0);
        last_s     = ((idx_s & GROUP_MASK) == GROUP_MASK);
        bin_s      = BIN_W'(idx_s >> GSHIFT);
        case (eff_mode_s)
            MODE_PEAK: acc_next_s = (first_s || (acc_r < ACC_W'(mag_s))) ? ACC_W'(mag_s) : acc_r;
            MODE_AVG:  acc_next_s = (first_s ? '0 : acc_r) + ACC_W'(mag_s);
            default:   acc_next_s = first_s ? ACC_W'(i_src_real) : acc_r;
        endcase
        if (eff_mode_s == MODE_AVG) begin
            result_s = DATA_W'(acc_next_s >> GSHIFT);
        end else begin
            result_s = acc_next_s[DATA_W-1:0];
        end
    end

    // Source FSM, accumulation, shadow bank and commit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= S_IDLE;
            src_cnt_r     <= '0;
            mode_r        <= MODE_DECIM;
            acc_r         <= '0;
            bins_r        <= '0;
            frame_done_r  <= 1'b0;
            framing_err_r <= 1'b0;
            fft_error_r   <= 2'b00;
            for (int k = 0; k < NUM_BINS; k++) begin
                shadow_r[k] <= '0;
            end
        end else begin
            frame_done_r <= 1'b0;
            if (i_src_valid) begin
                fft_error_r <= fft_error_r | i_src_error;
            end
            if (process_s && in_range_s) begin
                if (last_s) begin
                    shadow_r[bin_s] <= result_s;
                    acc_r           <= '0;
                end else begin
                    acc_r <= acc_next_s;
                end
            end
            case (state_r)
                S_IDLE: begin
                    if (restart_s) begin
                        state_r   <= S_COLLECT;
                        src_cnt_r <= CNT_W'(1);
                        mode_r    <= eff_mode_s;
                    end
                end
                S_COLLECT: begin
                    if (restart_s) begin
                        framing_err_r <= 1'b1;
                        src_cnt_r     <= CNT_W'(1);
                        mode_r        <= eff_mode_s;
                    end else if (i_src_valid && i_src_eop) begin
                        state_r   <= S_IDLE;
                        src_cnt_r <= '0;
                        if (src_cnt_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            for (int k = 0; k < NUM_BINS; k++) begin
                                bins_r[k*DATA_W +: DATA_W] <= shadow_r[k];
                            end
                        end else begin
                            framing_err_r <= 1'b1;
                        end
                    end else if (i_src_valid) begin
                        src_cnt_r <= src_cnt_r + CNT_W'(1);
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: sink streaming, FIFO overflow, reduction
// modes, framing errors, sticky flags and asynchronous reset.
module tb_fft_frame_ctrl;

    localparam int DATA_W     = 16;
    localparam int FFT_LEN    = 512;
    localparam int NUM_BINS   = 32;
    localparam int FIFO_DEPTH = 8;

    logic                       i_clk = 1'b0;
    logic                       i_rst = 1'b1;
    logic                       i_sample_valid;
    logic [DATA_W-1:0]          i_sample;
    logic [1:0]                 i_mode;
    logic                       o_sink_valid;
    logic                       i_sink_ready;
    logic                       o_sink_sop;
    logic                       o_sink_eop;
    logic [DATA_W-1:0]          o_sink_real;
    logic                       i_src_valid;
    logic                       o_src_ready;
    logic                       i_src_sop;
    logic                       i_src_eop;
    logic [DATA_W-1:0]          i_src_real;
    logic [DATA_W-1:0]          i_src_imag;
    logic [1:0]                 i_src_error;
    logic [NUM_BINS*DATA_W-1:0] o_bins;
    logic                       o_frame_done;
    logic                       o_overflow;
    logic                       o_framing_err;
    logic [1:0]                 o_fft_error;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    fft_frame_ctrl #(
        .DATA_W     (DATA_W),
        .FFT_LEN    (FFT_LEN),
        .NUM_BINS   (NUM_BINS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_mode         (i_mode),
        .o_sink_valid   (o_sink_valid),
        .i_sink_ready   (i_sink_ready),
        .o_sink_sop     (o_sink_sop),
        .o_sink_eop     (o_sink_eop),
        .o_sink_real    (o_sink_real),
        .i_src_valid    (i_src_valid),
        .o_src_ready    (o_src_ready),
        .i_src_sop      (i_src_sop),
        .i_src_eop      (i_src_eop),
        .i_src_real     (i_src_real),
        .i_src_imag     (i_src_imag),
        .i_src_error    (i_src_error),
        .o_bins         (o_bins),
        .o_frame_done   (o_frame_done),
        .o_overflow     (o_overflow),
        .o_framing_err  (o_framing_err),
        .o_fft_error    (o_fft_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] bin_at(input int k);
        return o_bins[k*DATA_W +: DATA_W];
    endfunction

    // Mode is only honoured on the sop beat; later beats carry a different mode
    task automatic send_frame(input int n, input logic [1:0] mode, input bit sat0, input bit do_eop);
        for (int i = 0; i < n; i++) begin
            i_src_valid = 1'b1;
            i_src_sop   = (i == 0);
            i_src_eop   = do_eop && (i == n - 1);
            i_mode      = (i == 0) ? mode : (mode ^ 2'b01);
            if (sat0 && i < 8) begin
                i_src_real = 16'h8000;
                i_src_imag = 16'h8000;
            end else begin
                i_src_real = 16'(i);
                i_src_imag = 16'd0;
            end
            tick();
        end
        i_src_valid = 1'b0;
        i_src_sop   = 1'b0;
        i_src_eop   = 1'b0;
    endtask

    initial begin
        int beats, bad, sop_cnt, sop_beat, eop_cnt, eop_beat, eop_data, d0;
        i_sample_valid = 1'b0;
        i_sample       = 16'd0;
        i_mode         = 2'd0;
        i_sink_ready   = 1'b0;
        i_src_valid    = 1'b0;
        i_src_sop      = 1'b0;
        i_src_eop      = 1'b0;
        i_src_real     = 16'd0;
        i_src_imag     = 16'd0;
        i_src_error    = 2'b00;
        tick();
        tick();
        check("rst_sink_valid", o_sink_valid, 0);
        check("rst_bins_zero", {31'd0, |o_bins}, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_framing_err", o_framing_err, 0);
        check("rst_fft_error", o_fft_error, 0);
        check("src_ready", o_src_ready, 1);
        i_rst = 1'b0;
        tick();

        // Ramp of one full packet with the sink always ready
        i_sink_ready = 1'b1;
        beats = 0; bad = 0; sop_cnt = 0; sop_beat = -1; eop_cnt = 0; eop_beat = -1; eop_data = -1;
        for (int c = 0; c < 520; c++) begin
            i_sample_valid = (c < 512);
            i_sample       = 16'(c);
            if (o_sink_valid) begin
                if (o_sink_real !== 16'(beats)) bad++;
                if (o_sink_sop) begin sop_cnt++; sop_beat = beats; end
                if (o_sink_eop) begin eop_cnt++; eop_beat = beats; eop_data = int'(o_sink_real); end
                beats++;
            end
            tick();
        end
        i_sample_valid = 1'b0;
        check("ramp_beats", beats, 512);
        check("ramp_data_errs", bad, 0);
        check("ramp_sop_count", sop_cnt, 1);
        check("ramp_sop_beat", sop_beat, 0);
        check("ramp_eop_count", eop_cnt, 1);
        check("ramp_eop_beat", eop_beat, 511);
        check("ramp_eop_data", eop_data, 511);
        i_sample_valid = 1'b1;
        i_sample       = 16'h1234;
        tick();
        i_sample_valid = 1'b0;
        check("wrap_sop", o_sink_sop, 1);
        check("wrap_data", o_sink_real, 32'h1234);
        tick();
        check("wrap_drained", o_sink_valid, 0);

        // Stall the sink while nine samples arrive
        i_sink_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            i_sample_valid = (c < 9);
            i_sample       = 16'(100 + c);
            tick();
            if (c == 7) check("ovf_after_8", o_overflow, 0);
        end
        i_sample_valid = 1'b0;
        check("ovf_after_9", o_overflow, 1);
        check("stall_head", o_sink_real, 100);
        i_sink_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_sink_valid) begin
                check("drain_data", o_sink_real, 100 + beats);
                beats++;
            end
            tick();
        end
        check("drain_count", beats, 8);

        // Reduction modes
        send_frame(512, 2'd0, 1'b0, 1'b1);
        check("m0_done_pulse", o_frame_done, 1);
        tick();
        check("m0_done_single", o_frame_done, 0);
        check("m0_bin0", bin_at(0), 0);
        check("m0_bin1", bin_at(1), 8);
        check("m0_bin17", bin_at(17), 136);
        check("m0_bin31", bin_at(31), 248);
        check("m0_done_cnt", done_cnt, 1);
        send_frame(512, 2'd1, 1'b1, 1'b1);
        tick();
        check("m1_bin0_sat", bin_at(0), 65535);
        check("m1_bin1", bin_at(1), 15);
        check("m1_bin20", bin_at(20), 167);
        check("m1_bin31", bin_at(31), 255);
        send_frame(512, 2'd2, 1'b0, 1'b1);
        tick();
        check("m2_bin0", bin_at(0), 3);
        check("m2_bin5", bin_at(5), 43);
        check("m2_bin31", bin_at(31), 251);
        check("m2_no_frame_err", o_framing_err, 0);

        // Short packet, then a packet cut short by a new sop
        d0 = done_cnt;
        send_frame(301, 2'd0, 1'b0, 1'b1);
        tick();
        check("short_err", o_framing_err, 1);
        check("short_no_done", done_cnt, d0);
        check("short_bins_kept", bin_at(5), 43);
        send_frame(100, 2'd1, 1'b0, 1'b0);
        send_frame(512, 2'd0, 1'b0, 1'b1);
        check("restart_done", o_frame_done, 1);
        tick();
        check("restart_done_cnt", done_cnt, d0 + 1);
        check("restart_bin3", bin_at(3), 24);
        check("restart_bin31", bin_at(31), 248);
        check("restart_err_sticky", o_framing_err, 1);

        // FFT error flag from a single stray beat
        i_src_valid = 1'b1;
        i_src_error = 2'b01;
        tick();
        i_src_valid = 1'b0;
        i_src_error = 2'b00;
        check("fft_err_set", o_fft_error, 1);
        tick(); tick(); tick();
        check("fft_err_held", o_fft_error, 1);

        // Asynchronous reset in the middle of a sink packet
        i_sink_ready = 1'b1;
        for (int c = 0; c < 201; c++) begin
            i_sample_valid = 1'b1;
            i_sample       = 16'(500 + c);
            tick();
        end
        i_sample_valid = 1'b0;
        #1;
        check("mid_valid", o_sink_valid, 1);
        check("mid_no_sop", o_sink_sop, 0);
        i_rst = 1'b1;
        #1;
        check("arst_sink_valid", o_sink_valid, 0);
        check("arst_bins_zero", {31'd0, |o_bins}, 0);
        check("arst_overflow", o_overflow, 0);
        check("arst_framing_err", o_framing_err, 0);
        check("arst_fft_error", o_fft_error, 0);
        tick();
        i_rst = 1'b0;
        tick();

        // Refill to full, then push and pop together while full
        i_sink_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_sample_valid = 1'b1;
            i_sample       = 16'(300 + c);
            tick();
        end
        i_sample_valid = 1'b0;
        check("post_rst_sop", o_sink_sop, 1);
        check("post_rst_head", o_sink_real, 300);
        i_sink_ready   = 1'b1;
        i_sample_valid = 1'b1;
        i_sample       = 16'd308;
        tick();
        i_sample_valid = 1'b0;
        check("full_pushpop_no_ovf", o_overflow, 0);
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_sink_valid) begin
                check("full_drain_data", o_sink_real, 301 + beats);
                beats++;
            end
            tick();
        end
        check("full_drain_count", beats, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Parametrised successor to the single-channel FFT streaming controller. Buffers incoming audio samples, drives them into the external FFT core over its Avalon-ST sink with full ready/valid handshaking, and reduces the first FFT_LEN/2 output points into NUM_BINS display bins using a selectable reduction mode. The result is a double-buffered bin vector plus a frame-done pulse for the visualiser. The block sits between the audio DSP front end and the display renderer.

Parameters:
DATA_W, 16, sample and bin width
FFT_LEN, 512, FFT points per frame (power of 2)
NUM_BINS, 32, output bins; power of 2, at most FFT_LEN/2
FIFO_DEPTH, 8, input sample FIFO depth (power of 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_sample_valid  in  1  one-cycle strobe, new sample
i_sample  in  DATA_W  signed audio sample
i_mode  in  2  0 = decimate, 1 = peak, 2 = average; 3 is treated as 0
o_sink_valid  out  1  FFT sink valid
i_sink_ready  in  1  FFT sink ready
o_sink_sop  out  1  start of packet
o_sink_eop  out  1  end of packet
o_sink_real  out  DATA_W  sample to FFT; imaginary part and inverse flag are tied to 0 outside this block
i_src_valid  in  1  FFT source valid
o_src_ready  out  1  constant 1
i_src_sop  in  1  source start of packet
i_src_eop  in  1  source end of packet
i_src_real  in  DATA_W  signed real output
i_src_imag  in  DATA_W  signed imaginary output
i_src_error  in  2  FFT source error
o_bins  out  NUM_BINS*DATA_W  bin vector; bin k occupies bits [k*DATA_W +: DATA_W]
o_frame_done  out  1  one-cycle pulse, o_bins updated
o_overflow  out  1  sticky, input sample dropped
o_framing_err  out  1  sticky, bad source packet
o_fft_error  out  2  sticky OR of i_src_error

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk. Reset clears every register and output to 0: FIFO, sink counter, source counter, accumulators, shadow bank, o_bins and all flags. A mid-frame reset abandons the frame, and the next sink beat carries sop.
- Input FIFO:
  - A sample is pushed when i_sample_valid=1.
  - If the FIFO is full and no pop occurs that cycle, the sample is dropped and o_overflow is set.
  - A push and a pop in the same cycle while full are both accepted.
- Sink side:
  - o_sink_valid = FIFO not empty; o_sink_real = FIFO head.
  - A beat transfers when o_sink_valid && i_sink_ready; that pops the FIFO and increments sink_cnt.
  - o_sink_sop = (sink_cnt==0) && o_sink_valid; o_sink_eop = (sink_cnt==FFT_LEN-1) && o_sink_valid.
  - sink_cnt wraps from FFT_LEN-1 to 0 on transfer.
  - No combinational path from i_sink_ready to o_sink_valid.
- Source FSM, states S_IDLE and S_COLLECT:
  - S_IDLE: a valid beat with sop moves to S_COLLECT with src_cnt=1, processes the beat as index 0 and latches i_mode for the whole frame. Valid beats without sop are ignored.
  - S_COLLECT: each valid beat is processed at index src_cnt, then src_cnt increments.
  - Beat with eop at src_cnt==FFT_LEN-1: commit, then go to S_IDLE.
  - Beat with eop at any other count: discard the frame (no commit), set o_framing_err, go to S_IDLE.
  - Beat with sop in S_COLLECT: set o_framing_err and restart the frame at index 0.
- Reduction:
  - GROUP = FFT_LEN/(2*NUM_BINS); index i maps to bin i/GROUP. Indices >= FFT_LEN/2 are ignored.
  - mag = |re|+|im|, computed unsigned at DATA_W+1 bits and saturated to 2^DATA_W-1.
  - Mode 0: bin = re of the first index of the group (signed, raw).
  - Mode 1: bin = max mag over the group.
  - Mode 2: bin = (sum of mag over the group) >> log2(GROUP); the accumulator is DATA_W+log2(GROUP) bits wide.
  - At the last index of each group, the result is written to shadow[bin] and the accumulator clears.
- Commit: on the clock edge after the accepted eop beat, the shadow bank is copied to o_bins and o_frame_done=1 for exactly one cycle. o_bins is otherwise stable.
- o_fft_error |= i_src_error on every valid beat.

Decomposition:
- Package fft_frame_pkg holds:
  - mode enum MODE_DECIM, MODE_PEAK, MODE_AVG;
  - source state enum;
  - function mag_sat(re, im);
  - function clog2-based GROUP_SHIFT helper.
- Sub-module sample_fifo: synchronous FIFO with parameters WIDTH and DEPTH, and ports push, pop, full, empty, dout.

Test Plan:
- 512 samples, ramp 0..511, i_sink_ready=1 -> 512 sink beats; sop on beat 0 (data 0); eop on beat 511 (data 511); sink_cnt back to 0.
- i_sink_ready held 0 for 20 cycles while 9 samples arrive -> first 8 buffered; 9th dropped; o_overflow=1; release ready -> beats 0..7 in order.
- Source frame with re=i, im=0 for i<256, mode 0 -> o_frame_done one cycle after eop; bin k = 8k (bin 31 = 248).
- Same frame in mode 1 -> bin k = 8k+7; in mode 2 -> bin k = 8k+3 (floor of 8k+3.5); re=-32768, im=-32768 -> 65535 saturated.
- eop at src_cnt 300, then sop mid-frame in a second packet -> no o_frame_done for either; o_framing_err=1; o_bins unchanged; next good frame commits normally.
- i_rst pulsed at sink beat 200 -> all outputs 0 asynchronously; next accepted beat asserts o_sink_sop; i_src_error=2'b01 on one beat -> o_fft_error=01 held until reset.
